// File: rtl/shared_bus_xfer.sv
// shared_bus_xfer
// Moves one burst at a time from the requester granted by an upstream 3-way
// arbiter onto a shared valid/ready bus. It samples the owner and burst
// length at grant time, counts beats down to the last one, pulses done for
// the owner, then waits for the owner to drop its grant before it accepts a
// new one. If the owner drops its grant mid-burst, the burst is aborted.
//
// State table
//   state   | meaning
//   IDLE    | no owner; waiting for exactly one grant bit
//   XFER    | owner latched; beats offered on the bus until counter hits last
//   DONE    | one-cycle done pulse for the owner
//   RELEASE | owner still held; waiting for its grant bit to drop
//
// Ports
//   Clock, Resetn        : rising-edge clock, async active-low reset
//   g[3:1]               : grants, bit n belongs to requester n (3'b001 = req 1)
//   dat1..dat3, len1..3  : requester beat data and burst length in beats
//   bus_ready            : sink ready
//   bus_valid/data/last  : shared-bus beat, data is 0 when not valid
//   bus_src              : owning requester 1..3, 0 when no owner
//   done[3:1]            : one-cycle burst-complete pulse, bit n = requester n
//   abort                : one-cycle burst-aborted pulse
//   err                  : sticky flag, set when more than one grant is seen in IDLE
module shared_bus_xfer #(
  parameter int DW = 8,
  parameter int LW = 4
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic [3:1]    g,
  input  logic [DW-1:0] dat1,
  input  logic [DW-1:0] dat2,
  input  logic [DW-1:0] dat3,
  input  logic [LW-1:0] len1,
  input  logic [LW-1:0] len2,
  input  logic [LW-1:0] len3,
  input  logic          bus_ready,
  output logic          bus_valid,
  output logic [DW-1:0] bus_data,
  output logic          bus_last,
  output logic [1:0]    bus_src,
  output logic [3:1]    done,
  output logic          abort,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, XFER, DONE, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic [1:0]    src_nxt;
  logic          err_nxt;

  logic          one_hot, multi;
  logic [1:0]    g_idx;
  logic [LW-1:0] g_len;
  logic          own_g;
  logic [DW-1:0] own_dat;
  logic          xfer;

  // Grant decode, only acted on in IDLE
  always_comb begin
    one_hot = (g == 3'b001) || (g == 3'b010) || (g == 3'b100);
    multi   = (g != 3'b000) && !one_hot;
    g_idx   = 2'd3;
    g_len   = len3;
    if (g[1]) begin
      g_idx = 2'd1;
      g_len = len1;
    end else if (g[2]) begin
      g_idx = 2'd2;
      g_len = len2;
    end
  end

  // Owner's grant bit and data, selected by the latched owner
  always_comb begin
    own_g   = 1'b0;
    own_dat = '0;
    case (bus_src)
      2'd1: begin own_g = g[1]; own_dat = dat1; end
      2'd2: begin own_g = g[2]; own_dat = dat2; end
      2'd3: begin own_g = g[3]; own_dat = dat3; end
      default: ;
    endcase
  end

  always_comb begin
    bus_valid = (state == XFER);
    bus_data  = bus_valid ? own_dat : '0;
    bus_last  = bus_valid && (cnt == LW'(1));
    xfer      = bus_valid && bus_ready;
    // abort is raised in the XFER cycle whose edge sees the owner's grant gone
    abort     = bus_valid && !own_g;
    done      = 3'b000;
    if (state == DONE) begin
      case (bus_src)
        2'd1: done = 3'b001;
        2'd2: done = 3'b010;
        2'd3: done = 3'b100;
        default: done = 3'b000;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    src_nxt   = bus_src;
    err_nxt   = err;
    case (state)
      IDLE: begin
        src_nxt = 2'd0;
        if (multi) begin
          err_nxt = 1'b1;
        end else if (one_hot) begin
          src_nxt   = g_idx;
          cnt_nxt   = g_len;
          state_nxt = (g_len != '0) ? XFER : DONE;
        end
      end
      XFER: begin
        // a beat on the abort cycle still counts, but abort beats completion
        if (xfer) cnt_nxt = cnt - LW'(1);
        if (!own_g) begin
          state_nxt = IDLE;
          src_nxt   = 2'd0;
        end else if (xfer && bus_last) begin
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = RELEASE;
      RELEASE: begin
        if (!own_g) begin
          state_nxt = IDLE;
          src_nxt   = 2'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        src_nxt   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      bus_src <= 2'd0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bus_src <= src_nxt;
      err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_shared_bus_xfer.sv
// Directed bench for shared_bus_xfer; grant and done bit n = requester n.
module tb_shared_bus_xfer;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [3:1] g;
  logic [7:0] dat1, dat2, dat3;
  logic [3:0] len1, len2, len3;
  logic       bus_ready;
  logic       bus_valid;
  logic [7:0] bus_data;
  logic       bus_last;
  logic [1:0] bus_src;
  logic [3:1] done;
  logic       abort;
  logic       err;

  int n_total = 0;
  int n_bad   = 0;

  shared_bus_xfer #(.DW(8), .LW(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .g(g),
    .dat1(dat1), .dat2(dat2), .dat3(dat3),
    .len1(len1), .len2(len2), .len3(len3),
    .bus_ready(bus_ready), .bus_valid(bus_valid), .bus_data(bus_data),
    .bus_last(bus_last), .bus_src(bus_src), .done(done),
    .abort(abort), .err(err)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // check the full bus-side output set
  task automatic chk_bus(input string tag, input logic v, input logic [7:0] d,
                         input logic l, input logic [1:0] s, input logic [3:1] dn,
                         input logic ab);
    chk({tag, ".valid"}, 32'(bus_valid), 32'(v));
    chk({tag, ".data"},  32'(bus_data),  32'(d));
    chk({tag, ".last"},  32'(bus_last),  32'(l));
    chk({tag, ".src"},   32'(bus_src),   32'(s));
    chk({tag, ".done"},  32'(done),      32'(dn));
    chk({tag, ".abort"}, 32'(abort),     32'(ab));
  endtask

  initial begin
    Resetn = 1'b0; g = 3'b000; bus_ready = 1'b0;
    dat1 = 8'h11; dat2 = 8'h22; dat3 = 8'h33;
    len1 = 4'd0; len2 = 4'd0; len3 = 4'd0;
    #2;
    chk_bus("rst", 0, 8'h00, 0, 2'd0, 3'b000, 0);
    chk("rst.err", 32'(err), 0);
    step();
    Resetn = 1'b1;
    step();

    // requester 2, three beats, sink always ready
    g = 3'b010; len2 = 4'd3; dat2 = 8'hA5; bus_ready = 1'b1;
    #1 chk_bus("b2.idle", 0, 8'h00, 0, 2'd0, 3'b000, 0);
    step();
    chk_bus("b2.beat1", 1, 8'hA5, 0, 2'd2, 3'b000, 0);
    g = 3'b011;  // extra grant outside IDLE must not set err
    step();
    chk_bus("b2.beat2", 1, 8'hA5, 0, 2'd2, 3'b000, 0);
    step();
    chk_bus("b2.beat3", 1, 8'hA5, 1, 2'd2, 3'b000, 0);
    g = 3'b010;
    step();
    chk_bus("b2.done", 0, 8'h00, 0, 2'd2, 3'b010, 0);
    step();
    chk_bus("b2.rel", 0, 8'h00, 0, 2'd2, 3'b000, 0);
    step();
    chk_bus("b2.rel_hold", 0, 8'h00, 0, 2'd2, 3'b000, 0);
    g = 3'b000;
    step();
    chk_bus("b2.idle2", 0, 8'h00, 0, 2'd0, 3'b000, 0);
    chk("b2.err", 32'(err), 0);

    // requester 3, two beats, sink stalling every other cycle
    g = 3'b100; len3 = 4'd2; dat3 = 8'h3C; bus_ready = 1'b0;
    step();
    #1 chk_bus("b3.stall1", 1, 8'h3C, 0, 2'd3, 3'b000, 0);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    #1 chk_bus("b3.stall2", 1, 8'h3C, 1, 2'd3, 3'b000, 0);
    step();
    bus_ready = 1'b1;
    #1 chk_bus("b3.last", 1, 8'h3C, 1, 2'd3, 3'b000, 0);
    step();
    chk_bus("b3.done", 0, 8'h00, 0, 2'd3, 3'b000 | 3'b100, 0);
    step();
    g = 3'b000;
    step();
    chk_bus("b3.idle", 0, 8'h00, 0, 2'd0, 3'b000, 0);

    // requester 1, zero-length burst
    g = 3'b001; len1 = 4'd0; dat1 = 8'h77;
    step();
    chk_bus("z1.done", 0, 8'h00, 0, 2'd1, 3'b001, 0);
    step();
    chk_bus("z1.rel", 0, 8'h00, 0, 2'd1, 3'b000, 0);
    g = 3'b000;
    step();
    chk_bus("z1.idle", 0, 8'h00, 0, 2'd0, 3'b000, 0);

    // requester 1, five beats, grant dropped after two transfers
    g = 3'b001; len1 = 4'd5; dat1 = 8'h5A;
    step();
    chk_bus("a1.beat1", 1, 8'h5A, 0, 2'd1, 3'b000, 0);
    step();
    chk_bus("a1.beat2", 1, 8'h5A, 0, 2'd1, 3'b000, 0);
    step();
    g = 3'b000;
    #1 chk_bus("a1.abort", 1, 8'h5A, 0, 2'd1, 3'b000, 1);
    step();
    chk_bus("a1.idle", 0, 8'h00, 0, 2'd0, 3'b000, 0);
    step();
    chk_bus("a1.nodone", 0, 8'h00, 0, 2'd0, 3'b000, 0);

    // abort wins when the grant drops on the last-beat transfer
    g = 3'b001; len1 = 4'd1; dat1 = 8'hC3;
    step();
    g = 3'b000;
    #1 chk_bus("ap.last", 1, 8'hC3, 1, 2'd1, 3'b000, 1);
    step();
    chk_bus("ap.nodone", 0, 8'h00, 0, 2'd0, 3'b000, 0);
    chk("ap.err", 32'(err), 0);

    // multiple grants in IDLE: stay idle, err sticks through a legal burst
    g = 3'b011;
    step();
    chk_bus("mg.idle", 0, 8'h00, 0, 2'd0, 3'b000, 0);
    chk("mg.err", 32'(err), 1);
    g = 3'b010; len2 = 4'd1; dat2 = 8'h96;
    step();
    chk_bus("mg.beat", 1, 8'h96, 1, 2'd2, 3'b000, 0);
    step();
    chk_bus("mg.done", 0, 8'h00, 0, 2'd2, 3'b010, 0);
    chk("mg.err_hold", 32'(err), 1);
    g = 3'b000;
    step();
    step();
    chk("mg.err_idle", 32'(err), 1);

    // reset mid-burst, then a clean burst from requester 2
    g = 3'b001; len1 = 4'd6; dat1 = 8'hE1;
    step();
    step();
    chk_bus("rb.beat2", 1, 8'hE1, 0, 2'd1, 3'b000, 0);
    #2 Resetn = 1'b0;
    #1 chk_bus("rb.rst", 0, 8'h00, 0, 2'd0, 3'b000, 0);
    chk("rb.err", 32'(err), 0);
    g = 3'b000;
    step();
    Resetn = 1'b1;
    step();
    chk_bus("rb.idle", 0, 8'h00, 0, 2'd0, 3'b000, 0);
    g = 3'b010; len2 = 4'd2; dat2 = 8'h4B;
    step();
    chk_bus("rb.new1", 1, 8'h4B, 0, 2'd2, 3'b000, 0);
    step();
    chk_bus("rb.new2", 1, 8'h4B, 1, 2'd2, 3'b000, 0);
    step();
    chk_bus("rb.done", 0, 8'h00, 0, 2'd2, 3'b010, 0);
    g = 3'b000;
    step();
    step();
    chk_bus("rb.end", 0, 8'h00, 0, 2'd0, 3'b000, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end

endmodule
